// File: rtl/exp_fx_iter.sv
// Fixed-point e^x: x = k*ln2 + r, Horner Taylor series over r (one term per cycle), then shift by k.
// Result appears TERMS+3 cycles after the accept cycle and is held until out_ready; no input accepted while busy.
module exp_fx_iter #(
   parameter int DATA_WIDTH = 16,
   parameter int FIXED_PNT  = 8,
   parameter int TERMS      = 6,
   parameter int GUARD      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] num,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] exp_num,
   output logic                  sat
);
   localparam int IF   = FIXED_PNT + GUARD;
   localparam int KW   = DATA_WIDTH - FIXED_PNT + 2;
   localparam int AW   = IF + 2;
   localparam int PW   = DATA_WIDTH + IF + 3;
   localparam int RW   = DATA_WIDTH + GUARD + 4;
   localparam int MW   = 2 * AW + 1;
   localparam int MAXK = DATA_WIDTH - FIXED_PNT;
   localparam int BW   = AW + MAXK + 1;
   localparam int CW   = $clog2(TERMS + 1);
   localparam int MAXV = (1 << (DATA_WIDTH - 1)) - 1;

   // ln2 and 1/ln2 held at 32 fraction bits, rounded down to the internal precision
   localparam logic [63:0] LN2_Q32     = 64'd2977044472;
   localparam logic [63:0] INV_LN2_Q32 = 64'd6196328019;
   localparam logic [63:0] LN2_C       = (LN2_Q32 + (64'd1 << (31 - IF))) >> (32 - IF);
   localparam logic [63:0] INV_LN2_C   = (INV_LN2_Q32 + (64'd1 << (31 - IF))) >> (32 - IF);
   localparam logic signed [IF+2:0] LN2_S     = (IF+3)'(LN2_C);
   localparam logic signed [IF+2:0] INV_LN2_S = (IF+3)'(INV_LN2_C);
   localparam logic [AW-1:0] ONE = AW'(64'd1 << IF);

   typedef enum logic [2:0] {IDLE, REDUCE, SERIES, SCALE, DONE} state_t;

   state_t                  r_state, w_state_n;
   logic signed [DATA_WIDTH-1:0] r_x;
   logic signed [KW-1:0]    r_k;
   logic [IF:0]             r_r;
   logic [AW-1:0]           r_acc;
   logic [CW-1:0]           r_n;
   logic [DATA_WIDTH-1:0]   r_exp;
   logic                    r_sat;

   logic signed [PW-1:0]    w_prod;
   logic signed [KW-1:0]    w_k0, w_k, w_kneg;
   logic signed [RW-1:0]    w_r0, w_r;
   logic [MW-1:0]           w_ar, w_tr;
   logic [AW-1:0]           w_acc_n;
   logic [BW-1:0]           w_big, w_rnd;
   logic                    w_ovf, w_sat;
   logic [DATA_WIDTH-1:0]   w_exp;

   function automatic logic [IF:0] recip(input logic [CW-1:0] n);
      recip = '0;
      for (int i = 1; i <= TERMS; i++)
         if (n == CW'(i)) recip = (IF+1)'(((1 << IF) + i / 2) / i);
   endfunction

   // floor via arithmetic shift; one correction step absorbs constant rounding
   assign w_prod = PW'(r_x) * PW'(INV_LN2_S);
   assign w_k0   = KW'(w_prod >>> (FIXED_PNT + IF));
   assign w_r0   = (RW'(r_x) <<< GUARD) - RW'(w_k0) * RW'(LN2_S);

   always_comb begin
      w_k = w_k0;
      w_r = w_r0;
      if (w_r0 < 0) begin
         w_k = w_k0 - KW'(1);
         w_r = w_r0 + RW'(LN2_S);
      end else if (w_r0 >= RW'(LN2_S)) begin
         w_k = w_k0 + KW'(1);
         w_r = w_r0 - RW'(LN2_S);
      end
   end

   assign w_ar    = MW'(r_acc) * MW'(r_r);
   assign w_tr    = MW'(w_ar >> IF) * MW'(recip(r_n));
   assign w_acc_n = ONE + AW'(w_tr >> IF);

   always_comb begin
      w_kneg = -r_k;
      w_big  = '0;
      w_ovf  = 1'b0;
      if (r_k > KW'(MAXK))
         w_ovf = 1'b1;
      else if (r_k >= 0)
         w_big = BW'(r_acc) << r_k;
      else if (w_kneg < KW'(IF))
         w_big = BW'(r_acc) >> w_kneg;
      w_rnd = (w_big + BW'(1 << (GUARD - 1))) >> GUARD;
      w_sat = w_ovf || (w_rnd > BW'(MAXV));
      w_exp = w_sat ? DATA_WIDTH'(MAXV) : DATA_WIDTH'(w_rnd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_n = REDUCE;
         end
         REDUCE: w_state_n = SERIES;
         SERIES: if (r_n == CW'(1)) w_state_n = SCALE;
         SCALE:  w_state_n = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_k   <= '0;
         r_r   <= '0;
         r_acc <= '0;
         r_n   <= '0;
         r_exp <= '0;
         r_sat <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) r_x <= num;
            REDUCE: begin
               r_k   <= w_k;
               r_r   <= (IF+1)'(w_r);
               r_acc <= ONE;
               r_n   <= CW'(TERMS);
            end
            SERIES: begin
               r_acc <= w_acc_n;
               r_n   <= r_n - CW'(1);
            end
            SCALE: begin
               r_exp <= w_exp;
               r_sat <= w_sat;
            end
            default: ;
         endcase
      end
   end

   assign exp_num = r_exp;
   assign sat     = r_sat;
endmodule

// File: tb/tb_exp_fx_iter.sv
// Directed checks for exp_fx_iter (Q8.8 defaults): values, latency, throughput, backpressure, reset mid-op.
module tb_exp_fx_iter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] num = '0;
   logic        in_ready, out_valid, sat;
   logic [15:0] exp_num;

   int n_chk = 0;
   int n_bad = 0;

   exp_fx_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .num(num),
      .out_valid(out_valid), .out_ready(out_ready), .exp_num(exp_num), .sat(sat)
   );

   always #5 clk = ~clk;

   // expected results hand-computed as round(e^x * 256), clipped to 0x7FFF
   int vx   [12] = '{'h0000, 'h0100, 'hFF00, 'h0400, 'h0500, 'hF800,
                     'h8000, 'h0080, 'hFF80, 'h04DA, 'h04DB, 'h7FFF};
   int vexp [12] = '{256, 696, 94, 13977, 32767, 0, 0, 422, 155, 32753, 32767, 32767};
   int vtol [12] = '{0, 2, 2, 2, 0, 0, 0, 2, 2, 2, 0, 0};
   int vsat [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};

   task automatic chk(input string tag, input int got, input int want, input int tol);
      int d;
      d = got - want;
      if (d < 0) d = -d;
      n_chk++;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, want, tol);
      end
   endtask

   // lat = cycles from the accept cycle to the first cycle with out_valid
   task automatic run_op(input logic [15:0] x, output logic [15:0] y, output logic s, output int lat);
      int n;
      @(negedge clk);
      num = x; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      y = exp_num; s = sat;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] y;
      logic        s;
      int          lat, first, second, cnt;

      #12;
      chk("rst_in_ready", int'(in_ready), 1, 0);
      chk("rst_out_valid", int'(out_valid), 0, 0);
      chk("rst_exp_num", int'(exp_num), 0, 0);
      chk("rst_sat", int'(sat), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(16'(vx[i]), y, s, lat);
         chk($sformatf("exp_%04h", vx[i]), int'(y), vexp[i], vtol[i]);
         chk($sformatf("sat_%04h", vx[i]), int'(s), vsat[i], 0);
         chk($sformatf("lat_%04h", vx[i]), lat, 9, 0);
      end

      // back-to-back operands with out_ready held high
      @(negedge clk);
      num = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
      first = -1; second = -1;
      for (int c = 0; c < 40 && second < 0; c++) begin
         if (in_valid && in_ready) begin
            if (first < 0) first = c; else second = c;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("throughput", second - first, 10, 0);
      for (int c = 0; c < 30 && !out_valid; c++) @(negedge clk);
      @(negedge clk);

      // backpressure: result must hold while out_ready is low, second request waits
      num = 16'h0000; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      num = 16'h0080;
      for (int c = 0; c < 30 && !out_valid; c++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_vld_%0d", c), int'(out_valid), 1, 0);
         chk($sformatf("bp_exp_%0d", c), int'(exp_num), 256, 0);
         chk($sformatf("bp_rdy_%0d", c), int'(in_ready), 0, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("bp_hs_rdy", int'(in_ready), 0, 0);
      @(negedge clk);
      chk("bp_vld_drop", int'(out_valid), 0, 0);
      chk("bp_rdy_rise", int'(in_ready), 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      chk("bp2_lat", lat, 9, 0);
      chk("bp2_exp", int'(exp_num), 422, 2);
      @(negedge clk);

      // reset while the series is running
      num = 16'h0400; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 1, 0);
      chk("mid_rst_out_valid", int'(out_valid), 0, 0);
      chk("mid_rst_exp_num", int'(exp_num), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("mid_rst_no_out", cnt, 0, 0);
      run_op(16'h0100, y, s, lat);
      chk("post_rst_exp", int'(y), 696, 2);
      chk("post_rst_sat", int'(s), 0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
